wca_rx_iq_deframer: RTL and testbench

- Parameterised successor to the Lime receive-path selector.
- Deinterleaves CHANNELS multiplexed 12-bit I/Q ADC buses into paired I/Q words with a per-channel valid strobe.
- Also provides:
  - tx loopback, direct and crossed channel routing, and a ramp test pattern;
  - per-channel I/Q framing-loss detection.
- Sits between the RF chip pins and the DSP/RSSI/DC-offset blocks, clocked by the RF data clock.

---
 rtl/wca_rx_iq_deframer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_wca_rx_iq_deframer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/wca_rx_iq_deframer.sv
// wca_rx_iq_deframer: deinterleaves CHANNELS multiplexed I/Q ADC buses into
// paired I/Q words with a per-channel valid strobe, plus loopback, crossed
// routing, a ramp test pattern and per-channel framing-loss counters.
// Optional DC-bias blocker on captured pairs: define WCA_RX_DCBLOCK_EN.
//
// Per-channel FSM:
//   state  | meaning
//   WAIT_I | expecting an I word; a Q word here is an orphan (framing error)
//   HAVE_I | I word held; Q completes the pair, another I replaces it (error)
module wca_rx_iq_deframer #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 12,
  parameter int ERR_W    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic                      err_clear,
  input  logic [CHANNELS-1:0]       rx_iqsel,
  input  logic [CHANNELS*WIDTH-1:0] rx_data,
  input  logic [WIDTH-1:0]          tx_i,
  input  logic [WIDTH-1:0]          tx_q,
  input  logic                      tx_valid,
  output logic [CHANNELS*WIDTH-1:0] rx_i,
  output logic [CHANNELS*WIDTH-1:0] rx_q,
  output logic [CHANNELS-1:0]       rx_valid,
  output logic [CHANNELS-1:0]       sync_err,
  output logic [CHANNELS*ERR_W-1:0] err_count
);

  localparam logic [1:0] MODE_LOOP   = 2'd0;
  localparam logic [1:0] MODE_DIRECT = 2'd1;
  localparam logic [1:0] MODE_CROSS  = 2'd2;
  localparam logic [1:0] MODE_TEST   = 2'd3;

  typedef enum logic {WAIT_I = 1'b0, HAVE_I = 1'b1} state_t;

  state_t              state_q  [CHANNELS];
  state_t              state_d  [CHANNELS];
  logic [WIDTH-1:0]    hold_q   [CHANNELS];
  logic [WIDTH-1:0]    src_data [CHANNELS];
  logic [WIDTH-1:0]    i_q      [CHANNELS];
  logic [WIDTH-1:0]    q_q      [CHANNELS];
  logic [WIDTH-1:0]    i_d      [CHANNELS];
  logic [WIDTH-1:0]    q_d      [CHANNELS];
  logic [ERR_W-1:0]    cnt_q    [CHANNELS];
  logic [CHANNELS-1:0] src_iq, load_hold, pair_done, frm_err, valid_d, valid_q, sync_q;
  logic [1:0]          mode_q;
  logic                toggle_q;
  logic [WIDTH-1:0]    ramp_q;
  logic                mode_chg, fsm_run;

`ifdef WCA_RX_DCBLOCK_EN
  localparam int AW = WIDTH + 8;
  localparam logic signed [AW:0] SAT_HI = {{10{1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW:0] SAT_LO = {{10{1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [AW-1:0] acc_i_q [CHANNELS];
  logic signed [AW-1:0] acc_q_q [CHANNELS];
  logic signed [AW-1:0] acc_i_d [CHANNELS];
  logic signed [AW-1:0] acc_q_d [CHANNELS];

  // Subtract the tracked bias (saturating) and advance the accumulator.
  function automatic void dc_apply(input logic [WIDTH-1:0] s, input logic signed [AW-1:0] acc,
                                   output logic [WIDTH-1:0] y, output logic signed [AW-1:0] acc_n);
    logic signed [AW:0] sx, ax, diff;
    sx   = {{9{s[WIDTH-1]}}, s};
    ax   = {acc[AW-1], acc >>> 8};
    diff = sx - ax;
    if (diff > SAT_HI)      y = {1'b0, {(WIDTH-1){1'b1}}};
    else if (diff < SAT_LO) y = {1'b1, {(WIDTH-1){1'b0}}};
    else                    y = diff[WIDTH-1:0];
    acc_n = acc + $signed(diff[AW-1:0]);
  endfunction
`endif

  assign mode_chg = (mode != mode_q);
  assign fsm_run  = enable & ~mode_chg & ((mode == MODE_DIRECT) | (mode == MODE_CROSS));

  // Map physical input lanes onto logical channels (straight or mirrored)
  always_comb begin
    src_iq = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (mode == MODE_CROSS) begin
        src_iq[k]   = rx_iqsel[CHANNELS-1-k];
        src_data[k] = rx_data[(CHANNELS-1-k)*WIDTH +: WIDTH];
      end else begin
        src_iq[k]   = rx_iqsel[k];
        src_data[k] = rx_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // FSM state register and I hold register; hold is dropped whenever pairing stops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= WAIT_I;
        hold_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        if (!fsm_run)         hold_q[k] <= '0;
        else if (load_hold[k]) hold_q[k] <= src_data[k];
      end
    end
  end

  // Next-state logic; outside paired modes every FSM is parked in WAIT_I
  always_comb begin
    load_hold = '0;
    pair_done = '0;
    frm_err   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k] = WAIT_I;
      if (fsm_run) begin
        case (state_q[k])
          WAIT_I: begin
            if (src_iq[k]) begin
              load_hold[k] = 1'b1;
              state_d[k]   = HAVE_I;
            end else begin
              frm_err[k]   = 1'b1;
            end
          end
          HAVE_I: begin
            if (src_iq[k]) begin
              load_hold[k] = 1'b1;
              frm_err[k]   = 1'b1;
              state_d[k]   = HAVE_I;
            end else begin
              pair_done[k] = 1'b1;
            end
          end
          default: state_d[k] = WAIT_I;
        endcase
      end
    end
  end

  // Output data/valid for the next cycle; data holds unless a source fires
  always_comb begin
    valid_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      i_d[k] = i_q[k];
      q_d[k] = q_q[k];
`ifdef WCA_RX_DCBLOCK_EN
      acc_i_d[k] = acc_i_q[k];
      acc_q_d[k] = acc_q_q[k];
`endif
      if (enable && !mode_chg) begin
        case (mode)
          MODE_LOOP: begin
            if (tx_valid) begin
              i_d[k]     = tx_i;
              q_d[k]     = tx_q;
              valid_d[k] = 1'b1;
            end
          end
          MODE_TEST: begin
            if (!toggle_q) begin
              i_d[k]     = ramp_q + WIDTH'(k);
              q_d[k]     = ~(ramp_q + WIDTH'(k));
              valid_d[k] = 1'b1;
            end
          end
          default: begin
            if (pair_done[k]) begin
`ifdef WCA_RX_DCBLOCK_EN
              dc_apply(hold_q[k], acc_i_q[k], i_d[k], acc_i_d[k]);
              dc_apply(src_data[k], acc_q_q[k], q_d[k], acc_q_d[k]);
`else
              i_d[k] = hold_q[k];
              q_d[k] = src_data[k];
`endif
              valid_d[k] = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Output registers (one stage of latency from the completing word)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        i_q[k] <= '0;
        q_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < CHANNELS; k++) begin
        i_q[k] <= i_d[k];
        q_q[k] <= q_d[k];
      end
    end
  end

`ifdef WCA_RX_DCBLOCK_EN
  // Bias accumulators; a mode change restarts bias tracking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        acc_i_q[k] <= '0;
        acc_q_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        acc_i_q[k] <= mode_chg ? '0 : acc_i_d[k];
        acc_q_q[k] <= mode_chg ? '0 : acc_q_d[k];
      end
    end
  end
`endif

  // Previous mode and ramp generator; mode_q resets to direct so that a
  // direct-mode pair straddling a reset is seen as an orphan Q, not a mode change
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q   <= MODE_DIRECT;
      toggle_q <= 1'b0;
      ramp_q   <= '0;
    end else begin
      mode_q <= mode;
      if (!enable || mode_chg || mode != MODE_TEST) begin
        toggle_q <= 1'b0;
        ramp_q   <= '0;
      end else begin
        toggle_q <= ~toggle_q;
        if (!toggle_q) ramp_q <= ramp_q + WIDTH'(1);
      end
    end
  end

  // Sticky framing flags and saturating counters; clear has priority
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      for (int k = 0; k < CHANNELS; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (err_clear) begin
          sync_q[k] <= 1'b0;
          cnt_q[k]  <= '0;
        end else if (frm_err[k]) begin
          sync_q[k] <= 1'b1;
          if (cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + ERR_W'(1);
        end
      end
    end
  end

  assign rx_valid = valid_q;
  assign sync_err = sync_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign rx_i[g*WIDTH +: WIDTH]      = i_q[g];
    assign rx_q[g*WIDTH +: WIDTH]      = q_q[g];
    assign err_count[g*ERR_W +: ERR_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_wca_rx_iq_deframer.sv
// Directed bench for wca_rx_iq_deframer (CHANNELS=2, WIDTH=12, ERR_W=8).
module tb_wca_rx_iq_deframer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic        err_clear;
  logic [1:0]  rx_iqsel;
  logic [23:0] rx_data;
  logic [11:0] tx_i, tx_q;
  logic        tx_valid;
  logic [23:0] rx_i, rx_q;
  logic [1:0]  rx_valid, sync_err;
  logic [15:0] err_count;

  int checks   = 0;
  int failures = 0;

  wca_rx_iq_deframer #(.CHANNELS(2), .WIDTH(12), .ERR_W(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode),
    .err_clear(err_clear), .rx_iqsel(rx_iqsel), .rx_data(rx_data),
    .tx_i(tx_i), .tx_q(tx_q), .tx_valid(tx_valid),
    .rx_i(rx_i), .rx_q(rx_q), .rx_valid(rx_valid),
    .sync_err(sync_err), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] iq, input logic [11:0] d0, input logic [11:0] d1);
    rx_iqsel = iq;
    rx_data  = {d1, d0};
  endtask

  // Idle cycle with the block disabled; also lets a new mode settle
  task automatic idle(input logic [1:0] m);
    enable = 1'b0;
    mode   = m;
    drive(2'b00, 12'h0, 12'h0);
    tick();
  endtask

  int pulses;
  logic [11:0] ramp_exp;

  initial begin
    reset = 1'b0; enable = 1'b0; mode = 2'd1; err_clear = 1'b0;
    rx_iqsel = '0; rx_data = '0; tx_i = '0; tx_q = '0; tx_valid = 1'b0;
    tick(); tick();
    check_val("rst_valid", rx_valid, 2'b00);
    check_val("rst_rx_i", rx_i, 24'h0);
    check_val("rst_err_count", err_count, 16'h0);
    check_val("rst_sync_err", sync_err, 2'b00);
    reset = 1'b1;
    idle(2'd1);

    // Direct mode: two clean pairs on both channels
    enable = 1'b1;
    drive(2'b11, 12'h100, 12'h300); tick();
    check_val("dir_valid_c1", rx_valid, 2'b00);
    drive(2'b00, 12'h200, 12'h400); tick();
    check_val("dir_valid_c2", rx_valid, 2'b11);
    check_val("dir_pair1_i", rx_i, {12'h300, 12'h100});
    check_val("dir_pair1_q", rx_q, {12'h400, 12'h200});
    drive(2'b11, 12'h101, 12'h301); tick();
    check_val("dir_valid_c3", rx_valid, 2'b00);
    drive(2'b00, 12'h201, 12'h401); tick();
    check_val("dir_valid_c4", rx_valid, 2'b11);
    check_val("dir_pair2_i", rx_i, {12'h301, 12'h101});
    check_val("dir_pair2_q", rx_q, {12'h401, 12'h201});
    check_val("dir_no_err", {sync_err, err_count}, 18'h0);
    idle(2'd2);

    // Crossed mode: lane 1 feeds channel 0 and vice versa
    enable = 1'b1;
    drive(2'b11, 12'h011, 12'h0AA); tick();
    drive(2'b00, 12'h022, 12'h0BB); tick();
    check_val("crs_valid", rx_valid, 2'b11);
    check_val("crs_i", rx_i, {12'h011, 12'h0AA});
    check_val("crs_q", rx_q, {12'h022, 12'h0BB});
    idle(2'd1);

    // Framing: orphan Q, then I, double I, Q -> pair (6,7), two errors
    enable = 1'b1;
    drive(2'b00, 12'h0, 12'h0); tick();
    check_val("frm_orphan_cnt", err_count[7:0], 8'd1);
    drive(2'b11, 12'h5, 12'h0); tick();
    drive(2'b11, 12'h6, 12'h0); tick();
    drive(2'b00, 12'h7, 12'h0); tick();
    check_val("frm_valid", rx_valid[0], 1'b1);
    check_val("frm_pair_i0", rx_i[11:0], 12'h6);
    check_val("frm_pair_q0", rx_q[11:0], 12'h7);
    check_val("frm_err_count0", err_count[7:0], 8'd2);
    check_val("frm_sync_err0", sync_err[0], 1'b1);
    enable = 1'b0; err_clear = 1'b1; tick();
    check_val("clr_err_count", err_count, 16'h0);
    check_val("clr_sync_err", sync_err, 2'b00);
    // Clear and orphan error in the same cycle: clear wins
    enable = 1'b1; drive(2'b00, 12'h0, 12'h0); tick();
    check_val("clr_wins_cnt", err_count, 16'h0);
    check_val("clr_wins_sync", sync_err, 2'b00);
    err_clear = 1'b0;
    for (int n = 0; n < 254; n++) tick();
    check_val("sat_254", err_count[7:0], 8'd254);
    for (int n = 0; n < 46; n++) tick();
    check_val("sat_300", err_count, {8'd255, 8'd255});
    enable = 1'b0; err_clear = 1'b1; tick();
    err_clear = 1'b0;
    idle(2'd0);

    // Loopback: tx pair broadcast to all channels, iqsel ignored
    enable = 1'b1; tx_i = 12'h123; tx_q = 12'hEDC; tx_valid = 1'b1;
    drive(2'b00, 12'h0, 12'h0); tick();
    check_val("lpb_valid", rx_valid, 2'b11);
    check_val("lpb_i", rx_i, {12'h123, 12'h123});
    check_val("lpb_q", rx_q, {12'hEDC, 12'hEDC});
    tx_valid = 1'b0; tick();
    check_val("lpb_valid_off", rx_valid, 2'b00);
    check_val("lpb_hold_i", rx_i, {12'h123, 12'h123});
    check_val("lpb_no_err", err_count, 16'h0);

    // Test pattern entered with enable high: first cycle is the mode change
    mode = 2'd3; pulses = 0; ramp_exp = 12'h0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) check_val("tp_chg_hold_i", rx_i, {12'h123, 12'h123});
      check_val($sformatf("tp_valid_e%0d", e), rx_valid, (e % 2 == 0) ? 2'b11 : 2'b00);
      if (rx_valid == 2'b11) begin
        pulses++;
        check_val($sformatf("tp_i_e%0d", e), rx_i, {ramp_exp + 12'd1, ramp_exp});
        check_val($sformatf("tp_q_e%0d", e), rx_q, {~(ramp_exp + 12'd1), ~ramp_exp});
        ramp_exp = ramp_exp + 12'd1;
      end
    end
    check_val("tp_pulses", pulses, 4);
    idle(2'd1);

    // Reset between I and Q: the Q becomes an orphan
    enable = 1'b1;
    drive(2'b11, 12'h555, 12'h555); tick();
    reset = 1'b0; #2;
    check_val("mid_rst_async", {rx_valid, rx_i}, 26'h0);
    reset = 1'b1;
    drive(2'b00, 12'h666, 12'h666); tick();
    check_val("mid_rst_valid", rx_valid, 2'b00);
    check_val("mid_rst_err", err_count[7:0], 8'd1);
    check_val("mid_rst_sync", sync_err[0], 1'b1);
    enable = 1'b0; err_clear = 1'b1; tick();
    err_clear = 1'b0;

    // Enable dropped between I and Q: held I is discarded
    enable = 1'b1;
    drive(2'b11, 12'h777, 12'h777); tick();
    enable = 1'b0; tick();
    enable = 1'b1;
    drive(2'b00, 12'h888, 12'h888); tick();
    check_val("en_drop_valid", rx_valid, 2'b00);
    check_val("en_drop_err", err_count[7:0], 8'd1);
    check_val("en_drop_hold_i", rx_i, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
